// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM single-port memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states; the ack cycle is spent in ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_t;

  // Access length encodings (bytes-1).
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  // Owner of a grant decided in IDLE.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  // DM has priority unless IF has been starved up to the limit.
  function automatic owner_t pick_owner(input logic if_elig,
                                        input logic dm_elig,
                                        input logic at_limit);
    owner_t own;
    own = OWN_NONE;
    if (dm_elig && !(if_elig && at_limit)) begin
      own = OWN_DM;
    end else if (if_elig) begin
      own = OWN_IF;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF request, DM request and shared memory port signals.
// slave: the arbiter's view; master: requesters plus memory model.
interface mem_port_arbiter_if #(
  parameter int MADDR_L = 32,
  parameter int DATA_L  = 32
);
  // instruction fetch side
  logic               if_req;
  logic [MADDR_L-1:0] if_addr;
  logic [1:0]         if_len;
  logic               if_ack;
  logic [DATA_L-1:0]  if_data;
  logic               purge;
  // data memory side
  logic               dm_req;
  logic               dm_we;
  logic [MADDR_L-1:0] dm_addr;
  logic [1:0]         dm_len;
  logic [DATA_L-1:0]  dm_wdata;
  logic               dm_ack;
  logic [DATA_L-1:0]  dm_rdata;
  // shared memory port
  logic [MADDR_L-1:0] mem_addr;
  logic [1:0]         mem_len;
  logic [DATA_L-1:0]  mem_wdata;
  logic               mem_re;
  logic               mem_we;
  logic [DATA_L-1:0]  mem_rdata;
  logic               mem_done;

  modport slave (
    input  if_req, if_addr, if_len, purge,
    input  dm_req, dm_we, dm_addr, dm_len, dm_wdata,
    input  mem_rdata, mem_done,
    output if_ack, if_data, dm_ack, dm_rdata,
    output mem_addr, mem_len, mem_wdata, mem_re, mem_we
  );

  modport master (
    output if_req, if_addr, if_len, purge,
    output dm_req, dm_we, dm_addr, dm_len, dm_wdata,
    output mem_rdata, mem_done,
    input  if_ack, if_data, dm_ack, dm_rdata,
    input  mem_addr, mem_len, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive DM grants taken while IF was waiting.
module arb_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  localparam logic [3:0] LIM = LIMIT[3:0];

  logic [3:0] cnt_reg;

  // Clear wins over increment; the count never passes the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else if (clr) begin
      cnt_reg <= 4'd0;
    end else if (inc && (cnt_reg < LIM)) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign at_limit = (cnt_reg == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory.
// All outputs are registered; acks are one-cycle pulses after mem_done.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MADDR_L    = 32,
  parameter int DATA_L     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  arb_state_t         state_reg, state_next;
  logic               kill_reg, kill_next;
  logic               if_ack_reg, if_ack_next;
  logic               dm_ack_reg, dm_ack_next;
  logic [DATA_L-1:0]  if_data_reg, if_data_next;
  logic [DATA_L-1:0]  dm_rdata_reg, dm_rdata_next;
  logic [MADDR_L-1:0] mem_addr_reg, mem_addr_next;
  logic [1:0]         mem_len_reg, mem_len_next;
  logic [DATA_L-1:0]  mem_wdata_reg, mem_wdata_next;
  logic               mem_re_reg, mem_re_next;
  logic               mem_we_reg, mem_we_next;

  logic   if_elig, dm_elig;
  logic   streak_inc, streak_clr, at_limit;
  owner_t owner;

  // A request is only eligible while its own ack is low; purge hides IF.
  assign if_elig = bus.if_req && !if_ack_reg && !bus.purge;
  assign dm_elig = bus.dm_req && !dm_ack_reg;
  assign owner   = pick_owner(if_elig, dm_elig, at_limit);

  arb_starve_cnt #(
    .LIMIT (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (streak_clr),
    .inc      (streak_inc),
    .at_limit (at_limit)
  );

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next     = state_reg;
    kill_next      = kill_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_data_next   = if_data_reg;
    dm_rdata_next  = dm_rdata_reg;
    mem_addr_next  = mem_addr_reg;
    mem_len_next   = mem_len_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_re_next    = mem_re_reg;
    mem_we_next    = mem_we_reg;
    streak_inc     = 1'b0;
    streak_clr     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        kill_next  = 1'b0;
        streak_clr = !bus.if_req;
        if (owner == OWN_DM) begin
          mem_addr_next  = bus.dm_addr;
          mem_len_next   = bus.dm_len;
          mem_wdata_next = bus.dm_wdata;
          mem_re_next    = !bus.dm_we;
          mem_we_next    = bus.dm_we;
          streak_inc     = if_elig;
          state_next     = ST_BUSY_DM;
        end else if (owner == OWN_IF) begin
          mem_addr_next  = bus.if_addr;
          mem_len_next   = bus.if_len;
          mem_wdata_next = '0;
          mem_re_next    = 1'b1;
          mem_we_next    = 1'b0;
          streak_clr     = 1'b1;
          state_next     = ST_BUSY_IF;
        end
      end

      ST_BUSY_IF: begin
        if (bus.purge) begin
          kill_next = 1'b1;
        end
        if (bus.mem_done) begin
          mem_re_next = 1'b0;
          mem_we_next = 1'b0;
          // A killed fetch finishes on the memory side but is never delivered.
          if (!kill_reg && !bus.purge) begin
            if_data_next = bus.mem_rdata;
            if_ack_next  = 1'b1;
          end
          kill_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_BUSY_DM: begin
        if (bus.mem_done) begin
          mem_re_next = 1'b0;
          mem_we_next = 1'b0;
          if (!mem_we_reg) begin
            dm_rdata_next = bus.mem_rdata;
          end
          dm_ack_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      kill_reg      <= 1'b0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_data_reg   <= '0;
      dm_rdata_reg  <= '0;
      mem_addr_reg  <= '0;
      mem_len_reg   <= '0;
      mem_wdata_reg <= '0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      kill_reg      <= kill_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_data_reg   <= if_data_next;
      dm_rdata_reg  <= dm_rdata_next;
      mem_addr_reg  <= mem_addr_next;
      mem_len_reg   <= mem_len_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_re_reg    <= mem_re_next;
      mem_we_reg    <= mem_we_next;
    end
  end

  assign bus.if_ack    = if_ack_reg;
  assign bus.if_data   = if_data_reg;
  assign bus.dm_ack    = dm_ack_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_len   = mem_len_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_we    = mem_we_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: table of single transactions plus hand-written
// collision, starvation, purge and reset sequences.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.MADDR_L(32), .DATA_L(32)) bus ();

  mem_port_arbiter #(
    .MADDR_L    (32),
    .DATA_L     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // memory model: asserts mem_done mem_lat cycles after the grant edge
  int          mem_lat   = 1;
  logic [31:0] mem_rdval = '0;
  logic        resp_done = 1'b0;
  logic        late_done = 1'b0;
  int          resp_cnt  = 0;

  assign bus.mem_done  = resp_done | late_done;
  assign bus.mem_rdata = mem_rdval;

  always @(posedge clk) begin
    #1;
    if ((bus.mem_re || bus.mem_we) && !resp_done) begin
      resp_cnt = resp_cnt + 1;
      if (resp_cnt >= mem_lat) resp_done = 1'b1;
    end else begin
      resp_done = 1'b0;
      resp_cnt  = 0;
    end
  end

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request, follow it to its ack and check everything on the way.
  task automatic run_vec(input string tag, input vec_t v);
    int   cyc;
    int   ack_other;
    bit   granted;
    bit   acked;
    logic stable_bad;
    logic own_ack;
    logic [31:0] data;
    mem_lat   = v.lat;
    mem_rdval = v.rdata;
    if (v.is_dm) begin
      bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_len = v.len;
      bus.dm_wdata = v.wdata; bus.dm_req = 1'b1;
    end else begin
      bus.if_addr = v.addr; bus.if_len = v.len; bus.if_req = 1'b1;
    end
    cyc = 0; ack_other = 0; granted = 0; acked = 0; stable_bad = 1'b0;
    while (!acked && cyc < 40) begin
      tick();
      cyc = cyc + 1;
      own_ack = v.is_dm ? bus.dm_ack : bus.if_ack;
      if (v.is_dm ? bus.if_ack : bus.dm_ack) ack_other = ack_other + 1;
      if (own_ack) begin
        acked = 1;
      end else if (bus.mem_re || bus.mem_we) begin
        if (!granted) begin
          granted = 1;
          chk({tag, "_addr"}, bus.mem_addr, v.addr);
          chk({tag, "_len"}, 32'(bus.mem_len), 32'(v.len));
          chk({tag, "_re"}, 32'(bus.mem_re), 32'(v.exp_re));
          chk({tag, "_we"}, 32'(bus.mem_we), 32'(v.exp_we));
          if (v.is_dm && v.we) chk({tag, "_wdata"}, bus.mem_wdata, v.wdata);
        end else if (bus.mem_addr !== v.addr || bus.mem_re !== v.exp_re ||
                     bus.mem_we !== v.exp_we) begin
          stable_bad = 1'b1;
        end
      end
    end
    chk({tag, "_granted"}, 32'(granted), 32'd1);
    chk({tag, "_acked"}, 32'(acked), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, "_stable"}, 32'(stable_bad), 32'd0);
    chk({tag, "_strobes_off"}, 32'(bus.mem_re | bus.mem_we), 32'd0);
    data = v.is_dm ? bus.dm_rdata : bus.if_data;
    chk({tag, "_data"}, data, v.exp_data);
    if (v.is_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
    tick();
    own_ack = v.is_dm ? bus.dm_ack : bus.if_ack;
    chk({tag, "_ack_one_cycle"}, 32'(own_ack), 32'd0);
    chk({tag, "_other_ack"}, 32'(ack_other), 32'd0);
  endtask

  vec_t vecs [6];
  vec_t v;
  logic grant_dm [6];
  int   n_grants;
  logic prev_strobe;
  int   re_cnt;
  int   ack_cnt;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_len = LEN_WORD; bus.purge = 1'b0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_len = LEN_WORD;
    bus.dm_wdata = '0;

    //          dm  we  addr          len       wdata         rdata         lat re  we  exp_data      exp_lat
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1000, LEN_WORD, 32'h0, 32'h2402_0005, 1, 1'b1, 1'b0, 32'h2402_0005, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2004, LEN_WORD, 32'h0, 32'h1122_3344, 2, 1'b1, 1'b0, 32'h1122_3344, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_2000, LEN_WORD, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 1, 1'b0, 1'b1, 32'h1122_3344, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1004, LEN_WORD, 32'h0, 32'h8C43_0000, 3, 1'b1, 1'b0, 32'h8C43_0000, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_2001, LEN_BYTE, 32'h0, 32'h0000_00EF, 1, 1'b1, 1'b0, 32'h0000_00EF, 2};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_2002, LEN_HALF, 32'h0000_BEEF, 32'h5A5A_5A5A, 10, 1'b0, 1'b1, 32'h0000_00EF, 11};

    // reset state
    tick(); tick();
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    rst = 1'b0;
    tick();
    $display("reset released, outputs checked");

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
      $display("vector %0d dm=%0b we=%0b addr=%h lat=%0d done", i, vecs[i].is_dm,
               vecs[i].we, vecs[i].addr, vecs[i].lat);
    end

    // collision: DM store wins, then the IF read
    mem_lat = 1; mem_rdval = 32'h0BAD_F00D;
    bus.dm_we = 1'b1; bus.dm_addr = 32'h2000; bus.dm_len = LEN_WORD; bus.dm_wdata = 32'hDEAD_BEEF;
    bus.if_addr = 32'h1008; bus.if_len = LEN_WORD;
    bus.dm_req = 1'b1; bus.if_req = 1'b1;
    tick();
    chk("col_dm_first_we", 32'(bus.mem_we), 32'd1);
    chk("col_dm_first_re", 32'(bus.mem_re), 32'd0);
    chk("col_dm_addr", bus.mem_addr, 32'h2000);
    chk("col_dm_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("col_dm_ack", 32'(bus.dm_ack), 32'd1);
    bus.dm_req = 1'b0;
    tick();
    chk("col_if_re", 32'(bus.mem_re), 32'd1);
    chk("col_if_addr", bus.mem_addr, 32'h1008);
    tick();
    chk("col_if_ack", 32'(bus.if_ack), 32'd1);
    chk("col_if_data", bus.if_data, 32'h0BAD_F00D);
    chk("col_dm_rdata_kept", bus.dm_rdata, 32'h0000_00EF);
    bus.if_req = 1'b0;
    tick();
    $display("collision sequence done");

    // starvation: both held; purge hides IF in DM ack cycles so DM can win
    mem_lat = 1; mem_rdval = 32'h5555_AAAA;
    bus.dm_we = 1'b0; bus.dm_addr = 32'h2010; bus.if_addr = 32'h1010;
    bus.dm_req = 1'b1; bus.if_req = 1'b1;
    n_grants = 0; prev_strobe = 1'b0;
    for (int c = 0; c < 60 && n_grants < 6; c++) begin
      tick();
      bus.purge = bus.dm_ack;
      if (bus.if_ack) bus.if_req = 1'b0;
      if ((bus.mem_re || bus.mem_we) && !prev_strobe) begin
        grant_dm[n_grants] = (bus.mem_addr == 32'h2010);
        n_grants = n_grants + 1;
      end
      prev_strobe = bus.mem_re || bus.mem_we;
    end
    chk("stv_grant_count", 32'(n_grants), 32'd6);
    for (int g = 0; g < n_grants; g++) begin
      chk($sformatf("stv_grant%0d_is_dm", g), 32'(grant_dm[g]), (g == 4) ? 32'd0 : 32'd1);
    end
    for (int c = 0; c < 10 && !bus.dm_ack; c++) tick();
    bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.purge = 1'b0;
    tick(); tick();
    $display("starvation sequence done, %0d grants", n_grants);

    // purge while the fetch is in flight
    mem_lat = 4; mem_rdval = 32'h7777_7777;
    bus.if_addr = 32'h1020; bus.if_req = 1'b1;
    tick();
    chk("pg_grant_re", 32'(bus.mem_re), 32'd1);
    bus.purge = 1'b1;
    tick();
    bus.purge = 1'b0; bus.if_req = 1'b0;
    re_cnt = 1; ack_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bus.mem_re) re_cnt = re_cnt + 1;
      if (bus.if_ack) ack_cnt = ack_cnt + 1;
    end
    chk("pg_re_held_cycles", 32'(re_cnt), 32'd3);
    chk("pg_no_ack", 32'(ack_cnt), 32'd0);
    chk("pg_if_data_kept", bus.if_data, 32'h5555_AAAA);
    v = '{1'b0, 1'b0, 32'h0000_3000, LEN_WORD, 32'h0, 32'h3C1D_0000, 1, 1'b1, 1'b0, 32'h3C1D_0000, 2};
    run_vec("pg_next", v);
    $display("purge sequence done");

    // reset during a DM store, then a stray mem_done
    mem_lat = 8;
    bus.dm_we = 1'b1; bus.dm_addr = 32'h2020; bus.dm_wdata = 32'h0102_0304; bus.dm_req = 1'b1;
    tick();
    chk("rs_busy_we", 32'(bus.mem_we), 32'd1);
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk("rs_async_we", 32'(bus.mem_we), 32'd0);
    chk("rs_async_re", 32'(bus.mem_re), 32'd0);
    chk("rs_async_acks", 32'({bus.if_ack, bus.dm_ack}), 32'd0);
    chk("rs_async_addr", bus.mem_addr, 32'd0);
    chk("rs_async_dm_rdata", bus.dm_rdata, 32'd0);
    bus.dm_req = 1'b0;
    tick();
    rst = 1'b0;
    late_done = 1'b1;
    ack_cnt = 0; re_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.if_ack || bus.dm_ack) ack_cnt = ack_cnt + 1;
      if (bus.mem_re || bus.mem_we) re_cnt = re_cnt + 1;
    end
    late_done = 1'b0;
    chk("rs_late_done_no_ack", 32'(ack_cnt), 32'd0);
    chk("rs_late_done_no_strobe", 32'(re_cnt), 32'd0);
    v = '{1'b0, 1'b0, 32'h0000_1000, LEN_WORD, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b0, 32'h1234_5678, 2};
    run_vec("rs_next", v);
    $display("reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
